pwm_challenge_top: RTL and testbench



---
 rtl/pwm_challenge_top.sv | 224 ++++++++++++++++++++++
 tb/tb_pwm_challenge_top.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_challenge_top.sv
// Two-channel PWM generator. A debounced push button steps the duty 25/50/75/100 %,
// and the active duty is shown on a 4-digit multiplexed 7-segment display.
//
// duty state | meaning
// DUTY_25    | threshold = PERIOD/4,     display "  25"
// DUTY_50    | threshold = 2*PERIOD/4,   display "  50"
// DUTY_75    | threshold = 3*PERIOD/4,   display "  75"
// DUTY_100   | threshold = PERIOD,       display " 100"
module pwm_challenge_top #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int PWM_FREQ_HZ = 50
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_adjust,
   output logic       pwm_out_1,
   output logic       pwm_out_2,
   output logic [6:0] segments,
   output logic [3:0] anodes
);

   localparam int PERIOD  = CLK_FREQ_HZ / PWM_FREQ_HZ;
   localparam int DEB     = CLK_FREQ_HZ / 100;
   localparam int REFRESH = CLK_FREQ_HZ / 1000;

   localparam int PW = $clog2(PERIOD + 1);
   localparam int DW = $clog2(DEB + 1);
   localparam int RW = $clog2(REFRESH + 1);

   localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD - 1);
   localparam logic [PW-1:0] TH_25        = PW'(PERIOD / 4);
   localparam logic [PW-1:0] TH_50        = PW'((PERIOD / 4) * 2);
   localparam logic [PW-1:0] TH_75        = PW'((PERIOD / 4) * 3);
   localparam logic [PW-1:0] TH_100       = PW'(PERIOD);
   localparam logic [DW-1:0] DEB_LAST     = DW'(DEB - 1);
   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH - 1);

   localparam logic [3:0] BLANK = 4'hF;

   typedef enum logic [1:0] {
      DUTY_25  = 2'd0,
      DUTY_50  = 2'd1,
      DUTY_75  = 2'd2,
      DUTY_100 = 2'd3
   } duty_t;

   logic          r_sync1;
   logic          r_sync2;
   logic          r_deb_level;
   logic          r_deb_prev;
   logic [DW-1:0] r_deb_cnt;
   logic          w_advance;

   duty_t         r_duty_pending;
   duty_t         w_duty_next;
   duty_t         r_duty_active;

   logic [PW-1:0] r_pwm_cnt;
   logic [PW-1:0] w_threshold;
   logic          w_pwm_on;
   logic          r_pwm1;
   logic          r_pwm2;

   logic [RW-1:0] r_ref_cnt;
   logic [1:0]    r_digit;
   logic [15:0]   w_digits;
   logic [3:0]    w_bcd;
   logic [6:0]    w_seg;
   logic [3:0]    r_anodes;
   logic [6:0]    r_segments;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= btn_adjust;
         r_sync2 <= r_sync1;
      end
   end

   // Debounced level starts "pressed" so a button held through reset must be
   // released (and debounced) before the next press can advance the duty.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_deb_level <= 1'b1;
         r_deb_prev  <= 1'b1;
         r_deb_cnt   <= '0;
      end else begin
         r_deb_prev <= r_deb_level;
         if (r_sync2 == r_deb_level) begin
            r_deb_cnt <= '0;
         end else if (r_deb_cnt == DEB_LAST) begin
            r_deb_level <= r_sync2;
            r_deb_cnt   <= '0;
         end else begin
            r_deb_cnt <= r_deb_cnt + DW'(1);
         end
      end
   end

   assign w_advance = r_deb_level & ~r_deb_prev;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_duty_pending <= DUTY_25;
      end else begin
         r_duty_pending <= w_duty_next;
      end
   end

   always_comb begin
      w_duty_next = r_duty_pending;
      if (w_advance) begin
         unique case (r_duty_pending)
            DUTY_25:  w_duty_next = DUTY_50;
            DUTY_50:  w_duty_next = DUTY_75;
            DUTY_75:  w_duty_next = DUTY_100;
            DUTY_100: w_duty_next = DUTY_25;
            default:  w_duty_next = DUTY_25;
         endcase
      end
   end

   always_comb begin
      w_threshold = TH_25;
      w_digits    = {BLANK, BLANK, 4'd2, 4'd5};
      unique case (r_duty_active)
         DUTY_25: begin
            w_threshold = TH_25;
            w_digits    = {BLANK, BLANK, 4'd2, 4'd5};
         end
         DUTY_50: begin
            w_threshold = TH_50;
            w_digits    = {BLANK, BLANK, 4'd5, 4'd0};
         end
         DUTY_75: begin
            w_threshold = TH_75;
            w_digits    = {BLANK, BLANK, 4'd7, 4'd5};
         end
         DUTY_100: begin
            w_threshold = TH_100;
            w_digits    = {BLANK, 4'd1, 4'd0, 4'd0};
         end
         default: begin
            w_threshold = TH_25;
            w_digits    = {BLANK, BLANK, 4'd2, 4'd5};
         end
      endcase
   end

   // The pending duty only reaches the comparator at the wrap, so a period is never cut short.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pwm_cnt     <= '0;
         r_duty_active <= DUTY_25;
      end else if (r_pwm_cnt == PERIOD_LAST) begin
         r_pwm_cnt     <= '0;
         r_duty_active <= r_duty_pending;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + PW'(1);
      end
   end

   assign w_pwm_on = (r_pwm_cnt < w_threshold);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pwm1 <= 1'b0;
         r_pwm2 <= 1'b0;
      end else begin
         r_pwm1 <= w_pwm_on;
         r_pwm2 <= ~w_pwm_on;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_ref_cnt <= '0;
         r_digit   <= 2'd0;
      end else if (r_ref_cnt == REFRESH_LAST) begin
         r_ref_cnt <= '0;
         r_digit   <= r_digit + 2'd1;
      end else begin
         r_ref_cnt <= r_ref_cnt + RW'(1);
      end
   end

   assign w_bcd = w_digits[{r_digit, 2'b00} +: 4];

   always_comb begin
      w_seg = 7'b1111111;
      case (w_bcd)
         4'd0:    w_seg = 7'b1000000;
         4'd1:    w_seg = 7'b1111001;
         4'd2:    w_seg = 7'b0100100;
         4'd3:    w_seg = 7'b0110000;
         4'd4:    w_seg = 7'b0011001;
         4'd5:    w_seg = 7'b0010010;
         4'd6:    w_seg = 7'b0000010;
         4'd7:    w_seg = 7'b1111000;
         4'd8:    w_seg = 7'b0000000;
         4'd9:    w_seg = 7'b0010000;
         default: w_seg = 7'b1111111;
      endcase
   end

   // Anode and segment registers load together so they always describe the same digit.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_anodes   <= 4'b1111;
         r_segments <= 7'b1111111;
      end else begin
         r_anodes   <= ~(4'b0001 << r_digit);
         r_segments <= w_seg;
      end
   end

   assign pwm_out_1 = r_pwm1;
   assign pwm_out_2 = r_pwm2;
   assign anodes    = r_anodes;
   assign segments  = r_segments;

endmodule

// File: tb/tb_pwm_challenge_top.sv
// Bench for pwm_challenge_top: random press/glitch timing checked against a
// duty-percentage model (high time per period, decimal display contents).
`timescale 1ns/1ps
module tb_pwm_challenge_top;

   localparam int CLK_HZ  = 100_000;
   localparam int PWM_HZ  = 50;
   localparam int PERIOD  = CLK_HZ / PWM_HZ;
   localparam int DEB     = CLK_HZ / 100;
   localparam int REFRESH = CLK_HZ / 1000;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       btn_adjust;
   logic       pwm_out_1;
   logic       pwm_out_2;
   logic [6:0] segments;
   logic [3:0] anodes;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int anchor = 0;
   int model_pct = 25;

   pwm_challenge_top #(.CLK_FREQ_HZ(CLK_HZ), .PWM_FREQ_HZ(PWM_HZ)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .btn_adjust (btn_adjust),
      .pwm_out_1  (pwm_out_1),
      .pwm_out_2  (pwm_out_2),
      .segments   (segments),
      .anodes     (anodes)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   function automatic logic [6:0] seg_code(input int v);
      case (v)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Right-aligned decimal rendering of the percentage, leading digits blank.
   function automatic logic [6:0] exp_seg(input int pct, input int pos);
      int v;
      if (pos == 0)      v = pct % 10;
      else if (pos == 1) v = (pct >= 10)  ? (pct / 10) % 10  : -1;
      else if (pos == 2) v = (pct >= 100) ? (pct / 100) % 10 : -1;
      else               v = -1;
      return (v < 0) ? 7'b1111111 : seg_code(v);
   endfunction

   function automatic int exp_high(input int pct);
      return PERIOD * pct / 100;
   endfunction

   function automatic int next_pct(input int pct);
      return (pct == 100) ? 25 : pct + 25;
   endfunction

   task automatic run_period(input int on_at, input int off_at, output int hi, output int comp_bad);
      hi = 0;
      comp_bad = 0;
      for (int i = 0; i < PERIOD; i++) begin
         if (i == on_at)  btn_adjust = 1'b1;
         if (i == off_at) btn_adjust = 1'b0;
         if (pwm_out_1 === 1'b1) hi++;
         if (pwm_out_2 !== ~pwm_out_1) comp_bad++;
         tick();
      end
   endtask

   task automatic align();
      while (((cyc - anchor) % PERIOD) != 0) tick();
   endtask

   task automatic find_anchor(output bit found);
      logic prev;
      found = 1'b0;
      prev = pwm_out_1;
      for (int i = 0; i < 2 * PERIOD && !found; i++) begin
         tick();
         if (pwm_out_1 === 1'b1 && prev === 1'b0) begin
            found = 1'b1;
            anchor = cyc;
         end
         prev = pwm_out_1;
      end
   endtask

   task automatic scan_display(input int pct, output int seg_bad, output int hot_bad,
                               output int order_bad, output logic [3:0] seen);
      int cur, run, pos, nchg;
      seg_bad = 0; hot_bad = 0; order_bad = 0; seen = 4'b0000;
      cur = -1; run = 0; nchg = 0;
      for (int i = 0; i < 5 * REFRESH; i++) begin
         if ($countones(~anodes) != 1) begin
            hot_bad++;
         end else begin
            pos = 0;
            for (int d = 0; d < 4; d++) if (anodes[d] == 1'b0) pos = d;
            seen[pos] = 1'b1;
            if (segments !== exp_seg(pct, pos)) seg_bad++;
            if (pos == cur) begin
               run++;
            end else begin
               if (cur >= 0) begin
                  if (pos != (cur + 1) % 4) order_bad++;
                  if (nchg > 0 && run != REFRESH) order_bad++;
                  nchg++;
               end
               cur = pos;
               run = 1;
            end
         end
         tick();
      end
   endtask

   task automatic test_display(input int pct);
      int sb, hb, ob;
      logic [3:0] seen;
      scan_display(pct, sb, hb, ob, seen);
      checks++;
      if (sb != 0) begin
         errors++;
         $display("FAIL display_%0d segment_errors got %0d expected 0", pct, sb);
      end
      checks++;
      if (hb != 0) begin
         errors++;
         $display("FAIL display_%0d onehot_anode_errors got %0d expected 0", pct, hb);
      end
      checks++;
      if (ob != 0) begin
         errors++;
         $display("FAIL display_%0d rotation_errors got %0d expected 0", pct, ob);
      end
      checks++;
      if (seen !== 4'b1111) begin
         errors++;
         $display("FAIL display_%0d digits_seen got %b expected 1111", pct, seen);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      btn_adjust = 1'b0;
      repeat (5) tick();
      checks++;
      if (pwm_out_1 !== 1'b0) begin
         errors++; $display("FAIL reset_pwm1 got %b expected 0", pwm_out_1);
      end
      checks++;
      if (pwm_out_2 !== 1'b0) begin
         errors++; $display("FAIL reset_pwm2 got %b expected 0", pwm_out_2);
      end
      checks++;
      if (anodes !== 4'b1111) begin
         errors++; $display("FAIL reset_anodes got %b expected 1111", anodes);
      end
      checks++;
      if (segments !== 7'b1111111) begin
         errors++; $display("FAIL reset_segments got %b expected 1111111", segments);
      end
      reset_n = 1'b1;
      model_pct = 25;
   endtask

   task automatic test_idle();
      bit found;
      int hi, cb;
      find_anchor(found);
      checks++;
      if (!found) begin
         errors++; $display("FAIL idle_anchor got none expected rising edge of pwm_out_1");
      end
      align();
      for (int p = 0; p < 2; p++) begin
         run_period(-1, -1, hi, cb);
         checks++;
         if (hi != exp_high(model_pct)) begin
            errors++; $display("FAIL idle_high_time got %0d expected %0d", hi, exp_high(model_pct));
         end
         checks++;
         if (cb != 0) begin
            errors++; $display("FAIL idle_complement got %0d errors expected 0", cb);
         end
      end
      test_display(model_pct);
   endtask

   // Press starts early in one period and is held into the next: the period in
   // which the press is recognised keeps the old duty, the next shows the new one,
   // and the rest of the hold produces no second advance.
   task automatic test_press();
      int hi, cb, offset, rel, old_pct;
      offset = $urandom_range(0, 800);
      rel = $urandom_range(200, 1800);
      old_pct = model_pct;
      model_pct = next_pct(model_pct);
      align();
      run_period(offset, -1, hi, cb);
      checks++;
      if (hi != exp_high(old_pct)) begin
         errors++; $display("FAIL press_%0d_same_period got %0d expected %0d", model_pct, hi, exp_high(old_pct));
      end
      run_period(-1, rel, hi, cb);
      checks++;
      if (hi != exp_high(model_pct)) begin
         errors++; $display("FAIL press_%0d_next_period got %0d expected %0d", model_pct, hi, exp_high(model_pct));
      end
      checks++;
      if (cb != 0) begin
         errors++; $display("FAIL press_%0d_complement got %0d errors expected 0", model_pct, cb);
      end
      run_period(-1, -1, hi, cb);
      checks++;
      if (hi != exp_high(model_pct)) begin
         errors++; $display("FAIL press_%0d_after_release got %0d expected %0d", model_pct, hi, exp_high(model_pct));
      end
      test_display(model_pct);
   endtask

   task automatic test_glitch();
      int hi, cb, len;
      for (int k = 0; k < 5; k++) begin
         len = (k == 0) ? DEB - 100 : $urandom_range(1, DEB - 100);
         btn_adjust = 1'b1;
         repeat (len) tick();
         btn_adjust = 1'b0;
         repeat ($urandom_range(5, 300)) tick();
      end
      repeat (10) tick();
      align();
      run_period(-1, -1, hi, cb);
      checks++;
      if (hi != exp_high(model_pct)) begin
         errors++; $display("FAIL glitch_ignored got %0d expected %0d", hi, exp_high(model_pct));
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      int hi, cb, bad;
      repeat ($urandom_range(1, 1500)) tick();
      btn_adjust = 1'b1;
      reset_n = 1'b0;
      tick();
      checks++;
      if (pwm_out_1 !== 1'b0 || pwm_out_2 !== 1'b0) begin
         errors++; $display("FAIL midreset_pwm got %b%b expected 00", pwm_out_1, pwm_out_2);
      end
      checks++;
      if (anodes !== 4'b1111 || segments !== 7'b1111111) begin
         errors++; $display("FAIL midreset_display got %b/%b expected 1111/1111111", anodes, segments);
      end
      bad = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (pwm_out_1 !== 1'b0 || pwm_out_2 !== 1'b0 || anodes !== 4'b1111 || segments !== 7'b1111111) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL midreset_hold got %0d bad cycles expected 0", bad);
      end
      reset_n = 1'b1;
      model_pct = 25;
      find_anchor(found);
      checks++;
      if (!found) begin
         errors++; $display("FAIL midreset_anchor got none expected rising edge of pwm_out_1");
      end
      align();
      for (int p = 0; p < 3; p++) begin
         run_period(-1, (p == 2) ? 0 : -1, hi, cb);
         checks++;
         if (hi != exp_high(25)) begin
            errors++; $display("FAIL midreset_held_period%0d got %0d expected %0d", p, hi, exp_high(25));
         end
      end
      test_display(25);
   endtask

   initial begin
      reset_n = 1'b0;
      btn_adjust = 1'b0;
      test_reset();
      test_idle();
      test_press();
      test_glitch();
      test_press();
      test_press();
      test_press();
      test_glitch();
      test_press();
      test_press();
      test_reset_mid();
      test_press();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
